// File: rtl/ibex_prefetch_queue_if.sv
// Core- and bus-side signals of the instruction prefetch queue.
// slave = prefetcher side, master = core plus memory side.
interface ibex_prefetch_queue_if;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        instr_rvalid_i;
  logic        busy_o;

  modport slave (
    input  req_i, branch_i, addr_i, ready_i,
    input  instr_gnt_i, instr_rdata_i,
    input  instr_err_i, instr_rvalid_i,
    output valid_o, rdata_o, addr_o, err_o,
    output instr_req_o, instr_addr_o, busy_o
  );

  modport master (
    output req_i, branch_i, addr_i, ready_i,
    output instr_gnt_i, instr_rdata_i,
    output instr_err_i, instr_rvalid_i,
    input  valid_o, rdata_o, addr_o, err_o,
    input  instr_req_o, instr_addr_o, busy_o
  );
endinterface

// File: rtl/ibex_prefetch_queue.sv
// Instruction prefetcher: credit-limited req/gnt/rvalid fetch engine
// feeding a registered word FIFO, with branch flush and error stop.
module ibex_prefetch_queue #(
  parameter int unsigned NumReqs   = 2,
  parameter int unsigned FifoDepth = 2,
  parameter bit          ErrStop   = 1'b0,
  parameter bit          ResetAll  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ibex_prefetch_queue_if.slave pq
);
  localparam int unsigned OW = $clog2(NumReqs + 1);
  localparam int unsigned FW = $clog2(FifoDepth + 1);
  localparam int unsigned QW = (NumReqs > 1) ? $clog2(NumReqs) : 1;
  localparam int unsigned PW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  logic          pend_q, pend_d;
  logic          pdisc_q, pdisc_d;
  logic          stop_q, stop_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [QW-1:0] aq_wp_q, aq_wp_d;
  logic [QW-1:0] aq_rp_q, aq_rp_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic          he_q, he_d;

  logic [31:0] paddr_q, paddr_d;
  logic [31:0] faddr_q, faddr_d;
  logic [31:0] aq_q [NumReqs];
  logic [31:0] aq_d [NumReqs];
  logic [31:0] fd_q [FifoDepth];
  logic [31:0] fd_d [FifoDepth];
  logic [31:0] fa_q [FifoDepth];
  logic [31:0] fa_d [FifoDepth];
  logic        fe_q [FifoDepth];
  logic        fe_d [FifoDepth];
  logic [31:0] hd_q, hd_d;
  logic [31:0] ha_q, ha_d;

  logic        new_req, req, gnt_fire, rvalid;
  logic        push, pop;
  logic [31:0] bus_addr, br_addr;

  assign br_addr  = {pq.addr_i[31:2], 2'b00};
  assign new_req  = pq.req_i & ~pend_q
                  & (outst_q < OW'(NumReqs))
                  & (~stop_q | pq.branch_i)
                  & (((32'(cnt_q) + 32'(outst_q)) < FifoDepth)
                     | pq.branch_i);
  assign req      = pend_q | new_req;
  assign bus_addr = pend_q ? paddr_q
                  : (pq.branch_i ? br_addr : faddr_q);
  assign gnt_fire = req & pq.instr_gnt_i;
  assign rvalid   = pq.instr_rvalid_i;
  assign push     = rvalid & ~pq.branch_i & (disc_q == '0);
  assign pop      = (cnt_q != '0) & pq.ready_i & ~pq.branch_i;

  always_comb begin
    pend_d  = req & ~pq.instr_gnt_i;
    pdisc_d = pend_d & pend_q & (pdisc_q | pq.branch_i);
    stop_d  = stop_q | (ErrStop & push & pq.instr_err_i);
    outst_d = outst_q + OW'(gnt_fire) - OW'(rvalid);
    disc_d  = disc_q + OW'(gnt_fire & pend_q & pdisc_q)
            - OW'(rvalid & (disc_q != '0));
    aq_wp_d = aq_wp_q;
    if (gnt_fire)
      aq_wp_d = (aq_wp_q == QW'(NumReqs - 1)) ? '0 : aq_wp_q + 1'b1;
    aq_rp_d = aq_rp_q;
    if (rvalid)
      aq_rp_d = (aq_rp_q == QW'(NumReqs - 1)) ? '0 : aq_rp_q + 1'b1;
    cnt_d = cnt_q + FW'(push) - FW'(pop);
    wp_d  = wp_q;
    if (push)
      wp_d = (wp_q == PW'(FifoDepth - 1)) ? '0 : wp_q + 1'b1;
    rp_d  = rp_q;
    if (pop)
      rp_d = (rp_q == PW'(FifoDepth - 1)) ? '0 : rp_q + 1'b1;
    // A new target request granted in the branch cycle must survive.
    if (pq.branch_i) begin
      stop_d = 1'b0;
      disc_d = outst_d - OW'(new_req & gnt_fire);
      cnt_d  = '0;
      wp_d   = '0;
      rp_d   = '0;
    end
  end

  always_comb begin
    paddr_d = pend_d ? bus_addr : paddr_q;
    faddr_d = faddr_q;
    if (new_req)
      faddr_d = bus_addr + 32'd4;
    else if (pq.branch_i)
      faddr_d = br_addr;
    aq_d = aq_q;
    if (gnt_fire)
      aq_d[aq_wp_q] = bus_addr;
    fd_d = fd_q;
    fa_d = fa_q;
    fe_d = fe_q;
    if (push) begin
      fd_d[wp_q] = pq.instr_rdata_i;
      fa_d[wp_q] = aq_q[aq_rp_q];
      fe_d[wp_q] = pq.instr_err_i;
    end
    hd_d = hd_q;
    ha_d = ha_q;
    he_d = he_q;
    // Head is registered; when empty it keeps the last word shown.
    if (cnt_d != '0) begin
      if (push && (cnt_q == FW'(pop))) begin
        hd_d = pq.instr_rdata_i;
        ha_d = aq_q[aq_rp_q];
        he_d = pq.instr_err_i;
      end else begin
        hd_d = fd_q[rp_d];
        ha_d = fa_q[rp_d];
        he_d = fe_q[rp_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q  <= 1'b0;
      pdisc_q <= 1'b0;
      stop_q  <= 1'b0;
      outst_q <= '0;
      disc_q  <= '0;
      aq_wp_q <= '0;
      aq_rp_q <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      he_q    <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pdisc_q <= pdisc_d;
      stop_q  <= stop_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      aq_wp_q <= aq_wp_d;
      aq_rp_q <= aq_rp_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      he_q    <= he_d;
    end
  end

  if (ResetAll) begin : g_pay_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        paddr_q <= '0;
        faddr_q <= '0;
        aq_q    <= '{default: '0};
        fd_q    <= '{default: '0};
        fa_q    <= '{default: '0};
        fe_q    <= '{default: 1'b0};
        hd_q    <= '0;
        ha_q    <= '0;
      end else begin
        paddr_q <= paddr_d;
        faddr_q <= faddr_d;
        aq_q    <= aq_d;
        fd_q    <= fd_d;
        fa_q    <= fa_d;
        fe_q    <= fe_d;
        hd_q    <= hd_d;
        ha_q    <= ha_d;
      end
    end
  end else begin : g_pay
    always_ff @(posedge clk_i) begin
      paddr_q <= paddr_d;
      faddr_q <= faddr_d;
      aq_q    <= aq_d;
      fd_q    <= fd_d;
      fa_q    <= fa_d;
      fe_q    <= fe_d;
      hd_q    <= hd_d;
      ha_q    <= ha_d;
    end
  end

  assign pq.valid_o      = (cnt_q != '0);
  assign pq.rdata_o      = hd_q;
  assign pq.addr_o       = ha_q;
  assign pq.err_o        = he_q;
  assign pq.instr_req_o  = req;
  assign pq.instr_addr_o = bus_addr;
  assign pq.busy_o       = req | (outst_q != '0);
endmodule
